// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone B4 pipelined master; cmd_* valid/ready command stream in, rsp_* one-cycle response pulse out, wb_* master port to a pipelined slave.
module wb_cmd_master #(
  parameter int g_data_width      = 32,
  parameter int g_addr_width      = 32,
  parameter int g_max_outstanding = 4,
  parameter int g_timeout         = 1023
) (
  input  logic                      clk_sys_i,
  input  logic                      rst_n_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [g_addr_width-1:0]   cmd_adr_i,
  input  logic [g_data_width-1:0]   cmd_dat_i,
  input  logic [g_data_width/8-1:0] cmd_sel_i,
  input  logic                      cmd_last_i,
  output logic                      rsp_valid_o,
  output logic [g_data_width-1:0]   rsp_dat_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [g_addr_width-1:0]   wb_adr_o,
  output logic [g_data_width-1:0]   wb_dat_o,
  output logic [g_data_width/8-1:0] wb_sel_o,
  input  logic [g_data_width-1:0]   wb_dat_i,
  input  logic                      wb_ack_i,
  input  logic                      wb_stall_i,
  input  logic                      wb_err_i,
  input  logic                      wb_rty_i
);
  localparam int SW = g_data_width / 8;
  localparam int TW = $clog2(g_timeout + 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, ABORT} state_t;
  state_t state_q, state_d;
  logic cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [g_addr_width-1:0] adr_q, adr_d;
  logic [g_data_width-1:0] dat_q, dat_d, rsp_dat_q, rsp_dat_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [3:0] inflight_q, inflight_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_tmo_q, rsp_tmo_d;
  logic busy, accept, term, tmo_hit, abort_rsp;

  always_comb begin
    busy        = state_q == ACTIVE || state_q == DRAIN;
    cmd_ready_o = rst_n_i && (state_q == IDLE || state_q == ACTIVE) && (!stb_q || !wb_stall_i)
                  && inflight_q < 4'(g_max_outstanding);
    accept      = cmd_valid_i && cmd_ready_o;
    tmo_hit     = busy && tmo_q == TW'(g_timeout);
    term        = busy && !tmo_hit && inflight_q != 4'd0 && (wb_ack_i || wb_err_i || wb_rty_i);
    abort_rsp   = tmo_hit || (state_q == ABORT && inflight_q != 4'd0);
    inflight_d  = inflight_q + 4'(accept) - 4'(term || abort_rsp);
    tmo_d       = (!busy || accept || term || tmo_hit) ? '0 : tmo_q + TW'(inflight_q != 4'd0);
    state_d     = tmo_hit                                        ? ABORT :
                  state_q == IDLE && accept                      ? (cmd_last_i ? DRAIN : ACTIVE) :
                  state_q == ACTIVE && accept && cmd_last_i      ? DRAIN :
                  state_q == DRAIN && inflight_d == 4'd0         ? IDLE :
                  state_q == ABORT && inflight_q <= 4'd1         ? IDLE : state_q;
    cyc_d       = state_d == ACTIVE || state_d == DRAIN;
    stb_d       = cyc_d && (accept || (stb_q && wb_stall_i));
    we_d        = accept ? cmd_we_i  : we_q;
    adr_d       = accept ? cmd_adr_i : adr_q;
    dat_d       = accept ? cmd_dat_i : dat_q;
    sel_d       = accept ? cmd_sel_i : sel_q;
    rsp_valid_d = term || abort_rsp;
    rsp_dat_d   = term ? wb_dat_i : '0;
    rsp_err_d   = abort_rsp || (term && (wb_err_i || wb_rty_i));
    rsp_tmo_d   = abort_rsp;
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      {cyc_q, stb_q, we_q, adr_q, dat_q, sel_q} <= '0;
      {inflight_q, tmo_q} <= '0;
      {rsp_valid_q, rsp_dat_q, rsp_err_q, rsp_tmo_q} <= '0;
    end else begin
      state_q     <= state_d;
      {cyc_q, stb_q, we_q, adr_q, dat_q, sel_q} <= {cyc_d, stb_d, we_d, adr_d, dat_d, sel_d};
      {inflight_q, tmo_q} <= {inflight_d, tmo_d};
      {rsp_valid_q, rsp_dat_q, rsp_err_q, rsp_tmo_q} <= {rsp_valid_d, rsp_dat_d, rsp_err_d, rsp_tmo_d};
    end
  end

  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = stb_q;
  assign wb_we_o       = we_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = sel_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_dat_o     = rsp_dat_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_tmo_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed self-checking bench for wb_cmd_master with a hand-scheduled Wishbone slave.
module tb_wb_cmd_master;
  logic clk_sys_i = 0, rst_n_i = 0;
  logic cmd_valid_i = 0, cmd_we_i = 0, cmd_last_i = 0;
  logic [31:0] cmd_adr_i = 0, cmd_dat_i = 0, wb_dat_i = 0;
  logic [3:0] cmd_sel_i = 0;
  logic wb_ack_i = 0, wb_stall_i = 0, wb_err_i = 0, wb_rty_i = 0;
  logic cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] rsp_dat_o, wb_adr_o, wb_dat_o;
  logic [3:0] wb_sel_o;
  int n_assert = 0, n_fail = 0;
  logic cq_we[8], cq_last[8];
  logic [31:0] cq_adr[8], cq_dat[8];
  logic [3:0] cq_sel[8];
  int ncmd = 0, k = 0;

  wb_cmd_master #(.g_data_width(32), .g_addr_width(32), .g_max_outstanding(4), .g_timeout(8)) dut (
    .clk_sys_i(clk_sys_i), .rst_n_i(rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i), .cmd_last_i(cmd_last_i),
    .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_stall_i(wb_stall_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  task automatic load(input int i, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic last);
    cq_we[i] = we; cq_adr[i] = adr; cq_dat[i] = dat; cq_sel[i] = sel; cq_last[i] = last;
  endtask

  task automatic drive_cmd();
    if (k < ncmd) begin
      cmd_valid_i = 1; cmd_we_i = cq_we[k]; cmd_adr_i = cq_adr[k];
      cmd_dat_i = cq_dat[k]; cmd_sel_i = cq_sel[k]; cmd_last_i = cq_last[k];
    end else begin
      cmd_valid_i = 0; cmd_we_i = 0; cmd_adr_i = 0; cmd_dat_i = 0; cmd_sel_i = 0; cmd_last_i = 0;
    end
  endtask

  task automatic step();
    logic fire;
    drive_cmd();
    #1;
    fire = cmd_valid_i && cmd_ready_o;
    @(posedge clk_sys_i);
    #1;
    if (fire) k++;
  endtask

  task automatic clear_slave();
    wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_stall_i = 0; wb_dat_i = 0;
  endtask

  task automatic test_reset();
    rst_n_i = 0; ncmd = 0; k = 0;
    step(); step();
    n_assert++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got cyc=%b stb=%b adr=%h rsp_valid=%b exp all 0", wb_cyc_o, wb_stb_o, wb_adr_o, rsp_valid_o);
    end
    n_assert++;
    if (cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", cmd_ready_o); end
    rst_n_i = 1;
    step();
    n_assert++;
    if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL idle_ready got=%b exp=1", cmd_ready_o); end
  endtask

  task automatic test_single_read();
    int cyc_cnt, rsp_cnt, rsp_c;
    logic [31:0] rdat;
    logic rerr;
    cyc_cnt = 0; rsp_cnt = 0; rsp_c = -1; rdat = 0; rerr = 1;
    ncmd = 1; k = 0; load(0, 0, 32'h10, 32'h0, 4'hF, 1);
    for (int c = 0; c <= 7; c++) begin
      if (wb_cyc_o) cyc_cnt++;
      if (c == 1) begin
        n_assert++;
        if ({wb_stb_o, wb_we_o, wb_adr_o} !== {1'b1, 1'b0, 32'h10}) begin
          n_fail++; $display("FAIL single_read_issue got stb=%b we=%b adr=%h exp stb=1 we=0 adr=10", wb_stb_o, wb_we_o, wb_adr_o);
        end
      end
      if (rsp_valid_o) begin rsp_cnt++; rsp_c = c; rdat = rsp_dat_o; rerr = rsp_err_o | rsp_timeout_o; end
      wb_ack_i = (c == 4); wb_dat_i = (c == 4) ? 32'hDEADBEEF : 32'h0;
      step();
    end
    clear_slave();
    n_assert++;
    if (cyc_cnt != 4) begin n_fail++; $display("FAIL single_read_cyc_len got=%0d exp=4", cyc_cnt); end
    n_assert++;
    if (rsp_cnt != 1 || rsp_c != 5) begin n_fail++; $display("FAIL single_read_rsp got count=%0d cycle=%0d exp count=1 cycle=5", rsp_cnt, rsp_c); end
    n_assert++;
    if (rdat !== 32'hDEADBEEF || rerr !== 1'b0) begin n_fail++; $display("FAIL single_read_data got dat=%h err=%b exp dat=deadbeef err=0", rdat, rerr); end
  endtask

  task automatic test_burst_writes();
    int stb_cnt, first_stb, last_stb, adr_bad, rsp_cnt, last_ack, drop;
    logic prev_stb, err_or, cyc_seen;
    stb_cnt = 0; first_stb = -1; last_stb = -1; adr_bad = 0; rsp_cnt = 0; last_ack = -1; drop = -1;
    prev_stb = 0; err_or = 0; cyc_seen = 0;
    ncmd = 4; k = 0;
    for (int i = 0; i < 4; i++) load(i, 1, 32'(4 * i), 32'h1000 + 32'(i), 4'hF, i == 3);
    for (int c = 0; c <= 8; c++) begin
      if (wb_stb_o) begin
        if (wb_adr_o !== 32'(4 * stb_cnt) || wb_dat_o !== 32'h1000 + 32'(stb_cnt) || wb_we_o !== 1'b1) adr_bad++;
        stb_cnt++; if (first_stb < 0) first_stb = c; last_stb = c;
      end
      if (rsp_valid_o) begin rsp_cnt++; err_or |= rsp_err_o | rsp_timeout_o; end
      if (wb_cyc_o) cyc_seen = 1;
      if (!wb_cyc_o && cyc_seen && drop < 0) drop = c;
      wb_ack_i = prev_stb; prev_stb = wb_stb_o;
      if (wb_ack_i) last_ack = c;
      step();
    end
    clear_slave();
    n_assert++;
    if (stb_cnt != 4 || first_stb != 1 || last_stb != 4) begin
      n_fail++; $display("FAIL burst_stb got count=%0d first=%0d last=%0d exp 4/1/4", stb_cnt, first_stb, last_stb);
    end
    n_assert++;
    if (adr_bad != 0) begin n_fail++; $display("FAIL burst_request got bad=%0d exp=0", adr_bad); end
    n_assert++;
    if (rsp_cnt != 4 || err_or !== 1'b0) begin n_fail++; $display("FAIL burst_rsp got count=%0d err=%b exp 4/0", rsp_cnt, err_or); end
    n_assert++;
    if (drop != last_ack + 1 || drop != 6) begin n_fail++; $display("FAIL burst_cyc_drop got=%0d exp=6", drop); end
  endtask

  task automatic test_stall_limit();
    logic rdy[20];
    int kk[20];
    int hold_bad, rsp_cnt;
    logic cyc16, cyc17;
    hold_bad = 0; rsp_cnt = 0; cyc16 = 0; cyc17 = 1;
    ncmd = 5; k = 0;
    for (int i = 0; i < 5; i++) load(i, 1, 32'h100 + 32'(4 * i), 32'hA5A50000 + 32'(i), 4'h3, i == 4);
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid_o) rsp_cnt++;
      if (c == 16) cyc16 = wb_cyc_o;
      if (c == 17) cyc17 = wb_cyc_o;
      if (c >= 1 && c <= 4 && {wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o} !== {1'b1, 32'h100, 32'hA5A50000, 4'h3}) hold_bad++;
      wb_stall_i = (c >= 1 && c <= 3);
      wb_ack_i = (c == 10) || (c >= 13 && c <= 16);
      kk[c] = k;
      drive_cmd();
      #1;
      rdy[c] = cmd_ready_o;
      step();
    end
    clear_slave();
    n_assert++;
    if (hold_bad != 0) begin n_fail++; $display("FAIL stall_hold got bad=%0d exp=0", hold_bad); end
    n_assert++;
    if ({rdy[1], rdy[2], rdy[3], rdy[4]} !== 4'b0001) begin
      n_fail++; $display("FAIL stall_ready got=%b%b%b%b exp=0001", rdy[1], rdy[2], rdy[3], rdy[4]);
    end
    n_assert++;
    if ({rdy[7], rdy[8], rdy[9], rdy[10], rdy[11]} !== 5'b00001) begin
      n_fail++; $display("FAIL limit_ready got=%b%b%b%b%b exp=00001", rdy[7], rdy[8], rdy[9], rdy[10], rdy[11]);
    end
    n_assert++;
    if (kk[11] != 4 || kk[12] != 5) begin n_fail++; $display("FAIL limit_fifth_accept got k11=%0d k12=%0d exp 4/5", kk[11], kk[12]); end
    n_assert++;
    if (rsp_cnt != 5 || cyc16 !== 1'b1 || cyc17 !== 1'b0) begin
      n_fail++; $display("FAIL limit_close got rsp=%0d cyc16=%b cyc17=%b exp 5/1/0", rsp_cnt, cyc16, cyc17);
    end
  endtask

  task automatic test_errors();
    logic [2:0] errs;
    logic [31:0] dats[3];
    int rsp_cnt;
    logic cyc4, cyc5;
    errs = 0; rsp_cnt = 0; cyc4 = 0; cyc5 = 1;
    ncmd = 3; k = 0;
    for (int i = 0; i < 3; i++) load(i, 0, 32'h20 + 32'(4 * i), 32'h0, 4'hF, i == 2);
    for (int c = 0; c <= 7; c++) begin
      if (rsp_valid_o && rsp_cnt < 3) begin errs[rsp_cnt] = rsp_err_o; dats[rsp_cnt] = rsp_dat_o; rsp_cnt++; end
      if (c == 4) cyc4 = wb_cyc_o;
      if (c == 5) cyc5 = wb_cyc_o;
      wb_ack_i = (c == 2); wb_err_i = (c == 3); wb_rty_i = (c == 4);
      wb_dat_i = (c == 2) ? 32'h11 : (c == 3) ? 32'h22 : (c == 4) ? 32'h33 : 32'h0;
      step();
    end
    clear_slave();
    n_assert++;
    if (rsp_cnt != 3 || errs !== 3'b110) begin n_fail++; $display("FAIL errors_seq got count=%0d err(2..0)=%b exp 3/110", rsp_cnt, errs); end
    n_assert++;
    if (dats[0] !== 32'h11 || dats[1] !== 32'h22 || dats[2] !== 32'h33) begin
      n_fail++; $display("FAIL errors_data got %h %h %h exp 11 22 33", dats[0], dats[1], dats[2]);
    end
    n_assert++;
    if (cyc4 !== 1'b1 || cyc5 !== 1'b0) begin n_fail++; $display("FAIL errors_cyc got cyc4=%b cyc5=%b exp 1/0", cyc4, cyc5); end
  endtask

  task automatic test_timeout();
    logic cyc10, cyc11, bad_rsp;
    int rsp_cnt, first_rsp;
    cyc10 = 0; cyc11 = 1; bad_rsp = 0; rsp_cnt = 0; first_rsp = -1;
    ncmd = 2; k = 0;
    load(0, 0, 32'h40, 32'h0, 4'hF, 0);
    load(1, 0, 32'h44, 32'h0, 4'hF, 1);
    for (int c = 0; c <= 15; c++) begin
      if (c == 10) cyc10 = wb_cyc_o;
      if (c == 11) cyc11 = wb_cyc_o;
      if (rsp_valid_o) begin
        rsp_cnt++; if (first_rsp < 0) first_rsp = c;
        if ({rsp_timeout_o, rsp_err_o, rsp_dat_o} !== {1'b1, 1'b1, 32'h0}) bad_rsp = 1;
      end
      wb_ack_i = (c == 11 || c == 13); wb_dat_i = wb_ack_i ? 32'hFFFFFFFF : 32'h0;
      step();
    end
    clear_slave();
    n_assert++;
    if (cyc10 !== 1'b1 || cyc11 !== 1'b0) begin n_fail++; $display("FAIL timeout_cyc got cyc10=%b cyc11=%b exp 1/0", cyc10, cyc11); end
    n_assert++;
    if (rsp_cnt != 2 || first_rsp != 11) begin n_fail++; $display("FAIL timeout_rsp got count=%0d first=%0d exp 2/11", rsp_cnt, first_rsp); end
    n_assert++;
    if (bad_rsp !== 1'b0) begin n_fail++; $display("FAIL timeout_fields got bad=%b exp=0", bad_rsp); end
  endtask

  task automatic test_reset_mid();
    logic cyc2, cyc4, stb4, rdy3;
    int rsp_cnt;
    cyc2 = 0; cyc4 = 1; stb4 = 1; rdy3 = 1; rsp_cnt = 0;
    ncmd = 2; k = 0;
    load(0, 0, 32'h80, 32'h0, 4'hF, 0);
    load(1, 0, 32'h84, 32'h0, 4'hF, 0);
    for (int c = 0; c <= 7; c++) begin
      if (rsp_valid_o) rsp_cnt++;
      if (c == 2) cyc2 = wb_cyc_o;
      if (c == 4) begin cyc4 = wb_cyc_o; stb4 = wb_stb_o; end
      rst_n_i = !(c == 3);
      wb_ack_i = (c == 3 || c == 4);
      if (c == 3) begin #1; rdy3 = cmd_ready_o; end
      step();
    end
    rst_n_i = 1;
    clear_slave();
    n_assert++;
    if (cyc2 !== 1'b1 || cyc4 !== 1'b0 || stb4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_bus got cyc2=%b cyc4=%b stb4=%b exp 1/0/0", cyc2, cyc4, stb4);
    end
    n_assert++;
    if (rsp_cnt != 0 || rdy3 !== 1'b0) begin n_fail++; $display("FAIL reset_mid_rsp got rsp=%0d ready=%b exp 0/0", rsp_cnt, rdy3); end
  endtask

  task automatic test_spurious_ack();
    logic r1, r2;
    ncmd = 0; k = 0;
    wb_ack_i = 1; wb_dat_i = 32'hCAFE;
    step();
    r1 = rsp_valid_o;
    clear_slave();
    step();
    r2 = rsp_valid_o;
    n_assert++;
    if ({r1, r2, wb_cyc_o} !== 3'b000) begin n_fail++; $display("FAIL spurious_ack got rsp=%b%b cyc=%b exp 00/0", r1, r2, wb_cyc_o); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_writes();
    test_stall_limit();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_spurious_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Synthesizable Wishbone B4 pipelined master: turns a valid/ready command stream into pipelined single-beat transactions on the Wishbone link and returns one response per command. It is the initiating end of the Wishbone link, driving adr/dat_o/sel/cyc/stb/we and consuming dat_i/ack/stall/err/rty. It sits between local control logic (sequencers, bridges, testbench-to-RTL adapters) and any Wishbone slave or crossbar port.

## Interface
Clocking: one clock, `clk_sys_i`. Reset: `rst_n_i`, synchronous, active-low.

**Parameters**
- `g_data_width`, default 32: data bus width. Must be a multiple of 8.
- `g_addr_width`, default 32: address width.
- `g_max_outstanding`, default 4: maximum in-flight requests (1..15).
- `g_timeout`, default 1023: cycles without a termination before abort (≥ 2).

**Ports**
- `clk_sys_i`, in, 1: system clock.
- `rst_n_i`, in, 1: synchronous reset, active-low.
- `cmd_valid_i`, in, 1: command present.
- `cmd_ready_o`, out, 1: command accepted when valid & ready.
- `cmd_we_i`, in, 1: 1 = write, 0 = read.
- `cmd_adr_i`, in, `g_addr_width`: address.
- `cmd_dat_i`, in, `g_data_width`: write data.
- `cmd_sel_i`, in, `g_data_width/8`: byte select.
- `cmd_last_i`, in, 1: final command of this bus cycle; cyc drops after it completes.
- `rsp_valid_o`, out, 1: one-cycle response pulse. No backpressure.
- `rsp_dat_o`, out, `g_data_width`: read data, captured from `wb_dat_i`.
- `rsp_err_o`, out, 1: termination was err or rty.
- `rsp_timeout_o`, out, 1: response generated by abort.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, out, 1: Wishbone control.
- `wb_adr_o`, out, `g_addr_width`: address.
- `wb_dat_o`, out, `g_data_width`: write data.
- `wb_sel_o`, out, `g_data_width/8`: byte select.
- `wb_dat_i`, in, `g_data_width`: read data.
- `wb_ack_i`, `wb_stall_i`, `wb_err_i`, `wb_rty_i`, in, 1: slave handshake and termination.

## Operation
- **States:** IDLE, ACTIVE, DRAIN, ABORT.
- **`inflight` counter** (4 bits):
  - +1 on command accept.
  - −1 on a termination (ack|err|rty) while `inflight` > 0.
  - Both in the same cycle: unchanged.
  - Terminations with `inflight` = 0 are ignored and produce no response.
- **`cmd_ready_o`** = rst_n_i & state∈{IDLE,ACTIVE} & (!wb_stb_o | !wb_stall_i) & inflight < g_max_outstanding.
- **IDLE:** cyc = stb = 0. On accept, load the request registers and raise cyc/stb.
  - `cmd_last_i` = 1 → DRAIN.
  - Otherwise → ACTIVE.
- **ACTIVE:**
  - stb stays high while `wb_stall_i` = 1; request registers are held stable.
  - A new accept in the same cycle stb is taken (stall = 0) reloads the registers and keeps stb high (back-to-back).
  - Otherwise stb falls. cyc stays high.
  - Accept with `cmd_last_i` → DRAIN.
- **DRAIN:** no accepts. When `inflight` reaches 0 (including the cycle of the final termination), cyc and stb drop → IDLE.
- **Responses:** each counted termination gives `rsp_valid_o` = 1 for one cycle.
  - `rsp_dat_o` = `wb_dat_i` (also captured on writes).
  - `rsp_err_o` = err|rty.
  - `rsp_timeout_o` = 0.
- **Error handling:** err/rty do not end the bus cycle. Responses are in issue order.
- **Timeout:**
  - The counter clears on any accept or termination, and counts while `inflight` > 0.
  - At `g_timeout` → ABORT: cyc/stb drop immediately.
  - ABORT emits `inflight` responses, one per cycle, each with `rsp_timeout_o` = 1, `rsp_err_o` = 1, `rsp_dat_o` = 0, then → IDLE.
  - Slave terminations during ABORT are ignored.
- **Reset mid-operation:** all state clears at the next edge. No responses are emitted for lost requests.

## Timing
- **Reset values:** all outputs 0, including `cmd_ready_o`. Counters 0, state IDLE.
- **Issue latency:** accept at edge N → `wb_cyc_o`/`wb_stb_o` high in cycle N+1.
- **Throughput:** one request per cycle when stall = 0 and the `inflight` limit is not reached.
- **Response latency:** a termination sampled at edge M → `rsp_valid_o` high in cycle M+1 (registered).
- **Cycle close:** the final termination in DRAIN at edge M → `wb_cyc_o` = 0 in cycle M+1. Earliest next accept is in cycle M+1 (IDLE).
- **Abort:** cyc = 0 in the cycle after the timeout is detected. The first timeout response appears in that same cycle.
- **Stall:** request outputs do not change while stb & stall.

## Test plan
- **Single read:** cmd read adr 0x10, last = 1. Slave acks 2 cycles after stb with dat 0xDEADBEEF → one rsp, dat 0xDEADBEEF, err 0. cyc is high exactly 4 cycles.
- **Burst of 4 writes:** adr 0x0/0x4/0x8/0xC with zero-wait slave, last on the 4th → stb high 4 consecutive cycles, 4 rsp pulses with err 0, cyc drops the cycle after the 4th ack.
- **Stall and outstanding limit:**
  - Stall held 3 cycles on the first request → adr/dat/sel held, cmd_ready_o = 0 while stalled.
  - With g_max_outstanding = 4 and no acks, the 5th command is not accepted until the first ack arrives.
- **Errors:** err on the 2nd of 3 reads, rty on the 3rd → rsp_err_o sequence 0,1,1. cyc stays up until the 3rd termination.
- **Timeout:** g_timeout = 8, 2 reads issued, slave silent → cyc drops 9 cycles after the last issue, followed by 2 rsp pulses with timeout = 1 and dat 0. A late ack is ignored.
- **Corner cases:**
  - rst_n_i asserted with 2 requests in flight → cyc/stb 0 the next cycle, no rsp.
  - A spurious ack in IDLE → no rsp.
